// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite row fetcher.
// On each line-start pulse it snapshots sprite positions, scans every sprite
// against the next scanline, reads each intersecting 32-pixel row from the
// shared sprite ROM, and writes the opaque pixels into a ping-pong line buffer.
// Optional feature macro: SPRITE_HFLIP_EN adds i_Sprite_Flip (horizontal mirror).
// Ports:
//   i_Clk, i_Reset (async, active high)
//   i_Line_Start, i_Next_Line             : line request
//   i_Sprite_X/Y/Enable[/Flip]            : packed sprite attributes
//   o_Mem_Read_En/Sprite_Id/Addr, i_Mem_Data : ROM read port (1-cycle latency)
//   o_Lb_Write_En/Addr/Data, o_Lb_Bank    : line-buffer write port
//   o_Busy, o_Done, o_Overrun             : status
module sprite_line_scheduler #(
   parameter int unsigned TILE_SIZE      = 32,
   parameter int unsigned NUM_SPRITES    = 5,
   parameter int unsigned H_VISIBLE_AREA = 640,
   parameter int unsigned V_VISIBLE_AREA = 480
) (
   input  logic                       i_Clk,
   input  logic                       i_Reset,
   input  logic                       i_Line_Start,
   input  logic [9:0]                 i_Next_Line,
   input  logic [NUM_SPRITES*10-1:0]  i_Sprite_X,
   input  logic [NUM_SPRITES*9-1:0]   i_Sprite_Y,
   input  logic [NUM_SPRITES-1:0]     i_Sprite_Enable,
`ifdef SPRITE_HFLIP_EN
   input  logic [NUM_SPRITES-1:0]     i_Sprite_Flip,
`endif
   output logic                       o_Mem_Read_En,
   output logic [2:0]                 o_Mem_Sprite_Id,
   output logic [9:0]                 o_Mem_Addr,
   input  logic [8:0]                 i_Mem_Data,
   output logic                       o_Lb_Write_En,
   output logic [9:0]                 o_Lb_Write_Addr,
   output logic [8:0]                 o_Lb_Write_Data,
   output logic                       o_Lb_Bank,
   output logic                       o_Busy,
   output logic                       o_Done,
   output logic                       o_Overrun
);

   localparam int unsigned COL_W = $clog2(TILE_SIZE);
   localparam int unsigned IDX_W = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(TILE_SIZE - 1);
   localparam logic [10:0]      H_LIM    = 11'(H_VISIBLE_AREA);
   localparam logic [9:0]       V_LIM    = 10'(V_VISIBLE_AREA);
   localparam logic [10:0]      TILE_11  = 11'(TILE_SIZE);

   typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [COL_W-1:0]           row_q, row_d, col_q, col_d;
   logic [9:0]                 line_q, line_d;
   logic [NUM_SPRITES*10-1:0]  sx_q, sx_d;
   logic [NUM_SPRITES*9-1:0]   sy_q, sy_d;
   logic [NUM_SPRITES-1:0]     sen_q, sen_d, flip_q, flip_d;
   logic                       bank_q, bank_d;
   logic                       rd_en_q, rd_en_d;
   logic [2:0]                 rd_id_q, rd_id_d;
   logic [9:0]                 rd_addr_q, rd_addr_d;
   logic                       pipe_vld_q, pipe_vld_d;
   logic [9:0]                 pipe_x_q, pipe_x_d;
   logic [COL_W-1:0]           pipe_col_q, pipe_col_d;
   logic                       lb_we_q, lb_we_d;
   logic [9:0]                 lb_addr_q, lb_addr_d;
   logic [8:0]                 lb_data_q, lb_data_d;
   logic                       busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;

   // Attributes of the sprite currently addressed by idx_q
   logic [9:0]  x_k;
   logic [8:0]  y_k;
   logic        en_k, fl_k, hit;
   logic [10:0] line_11, y_11, wsum;
   logic [COL_W-1:0] col_sel;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      row_d      = row_q;
      col_d      = col_q;
      line_d     = line_q;
      sx_d       = sx_q;
      sy_d       = sy_q;
      sen_d      = sen_q;
      flip_d     = flip_q;
      bank_d     = bank_q;
      rd_en_d    = 1'b0;
      rd_id_d    = 3'd0;
      rd_addr_d  = 10'd0;
      pipe_vld_d = 1'b0;
      pipe_x_d   = pipe_x_q;
      pipe_col_d = pipe_col_q;
      lb_we_d    = 1'b0;
      lb_addr_d  = lb_addr_q;
      lb_data_d  = lb_data_q;
      done_d     = 1'b0;
      ovr_d      = 1'b0;
      x_k        = 10'd0;
      y_k        = 9'd0;
      en_k       = 1'b0;
      fl_k       = 1'b0;
      col_sel    = '0;

      for (int k = 0; k < int'(NUM_SPRITES); k++) begin
         if (idx_q == IDX_W'(k)) begin
            x_k  = sx_q[k*10 +: 10];
            y_k  = sy_q[k*9 +: 9];
            en_k = sen_q[k];
            fl_k = flip_q[k];
         end
      end

      // 11-bit compare so a Y near 511 does not wrap past the tile bottom
      line_11 = {1'b0, line_q};
      y_11    = {2'b00, y_k};
      hit     = en_k && (line_q < V_LIM) && (line_11 >= y_11) && (line_11 < (y_11 + TILE_11));

      // Write stage: ROM data arrives one cycle after the read it belongs to
      wsum = 11'(pipe_x_q) + 11'(pipe_col_q);
      if (pipe_vld_q && (i_Mem_Data != 9'h000) && (wsum < H_LIM)) begin
         lb_we_d   = 1'b1;
         lb_addr_d = wsum[9:0];
         lb_data_d = i_Mem_Data;
      end

      case (state_q)
         IDLE: ;
         SCAN: begin
            if (hit) begin
               state_d = FETCH;
               row_d   = COL_W'(line_q - 10'(y_k));
               col_d   = '0;
            end else if (idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         FETCH: begin
            pipe_vld_d = 1'b1;
            pipe_x_d   = x_k;
            pipe_col_d = col_q;
            col_d      = col_q + 1'b1;
            if (col_q == LAST_COL) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DRAIN;
               end else begin
                  state_d = SCAN;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // A line start always (re)starts the scan; when busy it aborts the line
      if (i_Line_Start) begin
         ovr_d      = (state_q != IDLE);
         done_d     = 1'b0;
         state_d    = SCAN;
         idx_d      = '0;
         bank_d     = ~bank_q;
         line_d     = i_Next_Line;
         sx_d       = i_Sprite_X;
         sy_d       = i_Sprite_Y;
         sen_d      = i_Sprite_Enable;
`ifdef SPRITE_HFLIP_EN
         flip_d     = i_Sprite_Flip;
`else
         flip_d     = '0;
`endif
         pipe_vld_d = 1'b0;
         lb_we_d    = 1'b0;
      end

      // Read strobe register tracks the FETCH state cycle for cycle
      if (state_d == FETCH) begin
         col_sel   = fl_k ? (LAST_COL - col_d) : col_d;
         rd_en_d   = 1'b1;
         rd_id_d   = idx_q;
         rd_addr_d = 10'({row_d, col_sel});
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         line_q     <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         sen_q      <= '0;
         flip_q     <= '0;
         bank_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_id_q    <= '0;
         rd_addr_q  <= '0;
         pipe_vld_q <= 1'b0;
         pipe_x_q   <= '0;
         pipe_col_q <= '0;
         lb_we_q    <= 1'b0;
         lb_addr_q  <= '0;
         lb_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         row_q      <= row_d;
         col_q      <= col_d;
         line_q     <= line_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         sen_q      <= sen_d;
         flip_q     <= flip_d;
         bank_q     <= bank_d;
         rd_en_q    <= rd_en_d;
         rd_id_q    <= rd_id_d;
         rd_addr_q  <= rd_addr_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_x_q   <= pipe_x_d;
         pipe_col_q <= pipe_col_d;
         lb_we_q    <= lb_we_d;
         lb_addr_q  <= lb_addr_d;
         lb_data_q  <= lb_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
      end
   end

   assign o_Mem_Read_En   = rd_en_q;
   assign o_Mem_Sprite_Id = rd_id_q;
   assign o_Mem_Addr      = rd_addr_q;
   assign o_Lb_Write_En   = lb_we_q;
   assign o_Lb_Write_Addr = lb_addr_q;
   assign o_Lb_Write_Data = lb_data_q;
   assign o_Lb_Bank       = bank_q;
   assign o_Busy          = busy_q;
   assign o_Done          = done_q;
   assign o_Overrun       = ovr_q;

endmodule
